lab4d_fifo_drain: RTL and testbench

- Wishbone master readout engine for the LAB4 sample FIFO bank; the bus initiator that empties the per-LAB4 FIFOs.
- On a start pulse it walks every LAB4 enabled in a mask and issues WORDS_PER_LAB single-word reads to that LAB4's address window.
- Each returned 32-bit word goes out on a valid/ready stream toward the event builder.

---
 rtl/lab4d_fifo_drain_if.sv | 31 +++
 rtl/lab4d_fifo_drain.sv | 193 +++++++++++++++++++
 tb/tb_lab4d_fifo_drain.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab4d_fifo_drain_if.sv
// Bus bundle for the LAB4 FIFO drain engine: Wishbone read
// master toward the FIFO bank plus the outgoing word stream.
interface lab4d_fifo_drain_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [15:0] wbm_adr_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic [31:0] m_dat_o;
   logic        m_valid_o;
   logic        m_ready_i;
   logic        m_last_o;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o,
      output wbm_adr_o, wbm_sel_o,
      input  wbm_dat_i, wbm_ack_i,
      output m_dat_o, m_valid_o, m_last_o,
      input  m_ready_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
      input  wbm_adr_o, wbm_sel_o,
      output wbm_dat_i, wbm_ack_i,
      input  m_dat_o, m_valid_o, m_last_o,
      output m_ready_i
   );
endinterface

// File: rtl/lab4d_fifo_drain.sv
// LAB4 FIFO drain: walks enabled LAB4s and streams their words.
// Define LAB4_DRAIN_HEADER_EN to emit a header word per LAB4.
module lab4d_fifo_drain #(
   parameter int NUM_LAB4      = 24,
   parameter int WORDS_PER_LAB = 512
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [NUM_LAB4-1:0]  lab_mask_i,
   input  logic                 fifo_empty_i,
   lab4d_fifo_drain_if.master   bus,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 underrun_o
);

   localparam int L4W = $clog2(NUM_LAB4);
   localparam int WCW = $clog2(WORDS_PER_LAB) + 1;

   typedef enum logic [2:0] {
      IDLE, SCAN, REQ, HOLD, DONE, HDR
   } state_t;

   state_t              state_q;
   logic [NUM_LAB4-1:0] mask_q;
   logic [L4W-1:0]      idx_q;
   logic [WCW-1:0]      wcnt_q;
   logic                req_q;
   logic [15:0]         adr_q;
   logic [31:0]         dat_q;
   logic                valid_q;
   logic                last_q;
   logic                busy_q;
   logic                done_q;
   logic                unr_q;
   logic                abort_q;

   logic                above_d;
   logic                wlast_d;
   logic [15:0]         adr_d;
`ifdef LAB4_DRAIN_HEADER_EN
   logic [31:0]         hdr_d;
   assign hdr_d = {16'hA4B4, 3'b000, 13'(idx_q)};
`endif

   // Any enabled LAB4 beyond the current one decides m_last_o.
   always_comb begin
      above_d = 1'b0;
      for (int i = 0; i < NUM_LAB4; i++) begin
         if (mask_q[i] && (i > int'(idx_q))) above_d = 1'b1;
      end
   end

   assign wlast_d = (wcnt_q == WCW'(WORDS_PER_LAB - 1));
   assign adr_d   = {idx_q, {(16 - L4W){1'b0}}};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         mask_q  <= '0;
         idx_q   <= '0;
         wcnt_q  <= '0;
         req_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         unr_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  mask_q  <= lab_mask_i;
                  idx_q   <= '0;
                  wcnt_q  <= '0;
                  unr_q   <= 1'b0;
                  abort_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (lab_mask_i == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (abort_i) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else if (mask_q[idx_q]) begin
                  adr_q <= adr_d;
`ifdef LAB4_DRAIN_HEADER_EN
                  state_q <= HDR;
                  dat_q   <= hdr_d;
                  valid_q <= 1'b1;
`else
                  state_q <= REQ;
                  req_q   <= 1'b1;
                  unr_q   <= unr_q | fifo_empty_i;
`endif
               end else if (idx_q == L4W'(NUM_LAB4 - 1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
`ifdef LAB4_DRAIN_HEADER_EN
            HDR: begin
               if (abort_i) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  valid_q <= 1'b0;
               end else if (bus.m_ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= REQ;
                  req_q   <= 1'b1;
                  unr_q   <= unr_q | fifo_empty_i;
               end
            end
`endif
            REQ: begin
               if (abort_i) abort_q <= 1'b1;
               if (bus.wbm_ack_i) begin
                  req_q <= 1'b0;
                  // An abort seen during the read discards its data.
                  if (abort_i || abort_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     dat_q   <= bus.wbm_dat_i;
                     valid_q <= 1'b1;
                     last_q  <= wlast_d && !above_d;
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (abort_i) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
               end else if (bus.m_ready_i) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (wlast_d) begin
                     wcnt_q <= '0;
                     if (last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= SCAN;
                     end
                  end else begin
                     wcnt_q  <= wcnt_q + 1'b1;
                     state_q <= REQ;
                     req_q   <= 1'b1;
                     unr_q   <= unr_q | fifo_empty_i;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               abort_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.wbm_cyc_o = req_q;
   assign bus.wbm_stb_o = req_q;
   assign bus.wbm_we_o  = 1'b0;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_sel_o = 4'hF;
   assign bus.m_dat_o   = dat_q;
   assign bus.m_valid_o = valid_q;
   assign bus.m_last_o  = last_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign underrun_o    = unr_q;

endmodule

// File: tb/tb_lab4d_fifo_drain.sv
// Directed bench for lab4d_fifo_drain with a small Wishbone
// slave model and a stream monitor.
module tb_lab4d_fifo_drain;
   localparam int NL  = 24;
   localparam int WPL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          empty = 1'b0;
   logic [NL-1:0] mask = '0;
   logic          busy, done, unr;
   logic          ack = 1'b0;
   logic [31:0]   sdat = '0;
   logic          rdy = 1'b1;

   int checks = 0;
   int errors = 0;
   int pops = 0;
   int dly = 0;
   int cnt = 0;
   int viol = 0;
   int dones = 0;
   logic        vprev = 1'b0;
   logic        rprev = 1'b1;
   logic [31:0] dprev = '0;
   logic [15:0] adrs[$];
   logic [31:0] rxd[$];
   logic        rxl[$];

   int pb, rb, ab, db, vb;

   lab4d_fifo_drain_if bus ();

   assign bus.wbm_ack_i = ack;
   assign bus.wbm_dat_i = sdat;
   assign bus.m_ready_i = rdy;

   lab4d_fifo_drain #(
      .NUM_LAB4      (NL),
      .WORDS_PER_LAB (WPL)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .abort_i      (abort),
      .lab_mask_i   (mask),
      .fifo_empty_i (empty),
      .bus          (bus),
      .busy_o       (busy),
      .done_o       (done),
      .underrun_o   (unr)
   );

   always #5 clk = ~clk;

   // Slave pops one word per ack; monitor samples between edges.
   always @(negedge clk) begin
      if (ack && bus.wbm_stb_o) viol++;
      if (bus.m_valid_o && bus.wbm_stb_o) viol++;
      if (vprev && !rprev && bus.m_valid_o && bus.m_dat_o !== dprev)
         viol++;
      vprev = bus.m_valid_o;
      rprev = rdy;
      dprev = bus.m_dat_o;
      if (done) dones++;
      if (bus.m_valid_o && rdy) begin
         rxd.push_back(bus.m_dat_o);
         rxl.push_back(bus.m_last_o);
      end
      if (ack) begin
         ack = 1'b0;
      end else if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
         if (cnt >= dly) begin
            ack  = 1'b1;
            sdat = 32'h1000 + 32'(pops);
            adrs.push_back(bus.wbm_adr_o);
            pops++;
            cnt = 0;
         end else begin
            cnt++;
         end
      end else begin
         cnt = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input logic [NL-1:0] m);
      mask  = m;
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 500) begin
         step(1);
         k++;
      end
      chk(tag, 32'(done), 32'd1);
      step(1);
   endtask

   task automatic wait_stb(input string tag);
      int k;
      k = 0;
      while (bus.wbm_stb_o !== 1'b1 && k < 50) begin
         step(1);
         k++;
      end
      chk(tag, 32'(bus.wbm_stb_o), 32'd1);
   endtask

   task automatic snap();
      pb = pops;
      rb = rxd.size();
      ab = adrs.size();
      db = dones;
      vb = viol;
   endtask

   initial begin
      // Reset values, sampled while reset is held.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
      chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
      chk("rst_we", 32'(bus.wbm_we_o), 32'd0);
      chk("rst_adr", 32'(bus.wbm_adr_o), 32'd0);
      chk("rst_sel", 32'(bus.wbm_sel_o), 32'hF);
      chk("rst_dat", bus.m_dat_o, 32'd0);
      chk("rst_valid", 32'(bus.m_valid_o), 32'd0);
      chk("rst_last", 32'(bus.m_last_o), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_unr", 32'(unr), 32'd0);
      rst = 1'b0;
      step(1);

      // Single LAB4 drain.
      snap();
      pulse_start(24'h000001);
      chk("t1_busy", 32'(busy), 32'd1);
      wait_done("t1_done");
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_nwords", 32'(rxd.size() - rb), 32'd4);
      chk("t1_npops", 32'(pops - pb), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("t1_data", rxd[rb+k], 32'h1000 + 32'(pb + k));
         chk("t1_last", 32'(rxl[rb+k]), 32'(k == 3));
         chk("t1_adr", 32'(adrs[ab+k]), 32'h0000);
      end
      chk("t1_dones", 32'(dones - db), 32'd1);

      // Three LAB4s, including the top one.
      snap();
      pulse_start(24'h800005);
      wait_done("t2_done");
      chk("t2_nwords", 32'(rxd.size() - rb), 32'd12);
      chk("t2_npops", 32'(pops - pb), 32'd12);
      for (int k = 0; k < 12; k++) begin
         chk("t2_data", rxd[rb+k], 32'h1000 + 32'(pb + k));
         chk("t2_last", 32'(rxl[rb+k]), 32'(k == 11));
         chk("t2_adr", 32'(adrs[ab+k]),
             (k < 4) ? 32'h0000 : (k < 8) ? 32'h1000 : 32'hB800);
      end
      chk("t2_dones", 32'(dones - db), 32'd1);

      // Consumer stall mid-stream.
      snap();
      pulse_start(24'h000001);
      for (int k = 0; k < 200; k++) begin
         if (rxd.size() - rb >= 2) break;
         step(1);
      end
      rdy = 1'b0;
      step(10);
      rdy = 1'b1;
      wait_done("t3_done");
      chk("t3_nwords", 32'(rxd.size() - rb), 32'd4);
      chk("t3_npops", 32'(pops - pb), 32'd4);
      for (int k = 0; k < 4; k++)
         chk("t3_data", rxd[rb+k], 32'h1000 + 32'(pb + k));
      chk("t3_stall_viol", 32'(viol - vb), 32'd0);

      // Abort during an outstanding read with a slow ack.
      snap();
      dly = 3;
      pulse_start(24'h000001);
      wait_stb("t4_stb");
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      wait_done("t4_done");
      dly = 0;
      chk("t4_npops", 32'(pops - pb), 32'd1);
      chk("t4_nwords", 32'(rxd.size() - rb), 32'd0);
      chk("t4_dones", 32'(dones - db), 32'd1);
      chk("t4_valid", 32'(bus.m_valid_o), 32'd0);
      chk("t4_last", 32'(bus.m_last_o), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);

      // Empty mask finishes almost at once.
      snap();
      pulse_start('0);
      for (int k = 0; k < 2; k++) begin
         if (done === 1'b1) break;
         step(1);
      end
      chk("t5_done", 32'(done), 32'd1);
      step(2);
      chk("t5_npops", 32'(pops - pb), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);

      // Second start while busy is ignored.
      snap();
      pulse_start(24'h000001);
      step(2);
      chk("t6_busy", 32'(busy), 32'd1);
      pulse_start(24'h800005);
      wait_done("t6_done");
      chk("t6_npops", 32'(pops - pb), 32'd4);
      chk("t6_adr", 32'(adrs[ab+3]), 32'h0000);
      chk("t6_dones", 32'(dones - db), 32'd1);

      // Underrun is sticky until the next accepted start.
      empty = 1'b1;
      pulse_start(24'h000001);
      step(3);
      empty = 1'b0;
      wait_done("t7_done");
      chk("t7_unr", 32'(unr), 32'd1);
      step(5);
      chk("t7_unr_sticky", 32'(unr), 32'd1);
      pulse_start(24'h000001);
      chk("t7_unr_clr", 32'(unr), 32'd0);
      wait_done("t7_done2");
      chk("t7_unr_end", 32'(unr), 32'd0);

      // Asynchronous reset in the middle of a read.
      dly = 3;
      pulse_start(24'h000001);
      wait_stb("t8_stb");
      #2;
      rst = 1'b1;
      #1;
      chk("t8_cyc", 32'(bus.wbm_cyc_o), 32'd0);
      chk("t8_stb_low", 32'(bus.wbm_stb_o), 32'd0);
      chk("t8_busy", 32'(busy), 32'd0);
      step(2);
      rst = 1'b0;
      dly = 0;
      step(2);
      chk("t8_idle", 32'(busy), 32'd0);

      // Engine drains normally after the reset.
      snap();
      pulse_start(24'h000001);
      wait_done("t9_done");
      chk("t9_nwords", 32'(rxd.size() - rb), 32'd4);
      chk("t9_data", rxd[rb+3], 32'h1000 + 32'(pb + 3));
      chk("viol_total", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
